// File: rtl/k007232_pkg.sv
// Shared types for the K007232 sample-ROM responder.
// The K007232_ROM_PREFETCH_EN build uses the PREFETCH state and next_sa().
package k007232_pkg;

  localparam int unsigned SA_W = 17;
  localparam int unsigned DW   = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PREFETCH
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [SA_W-1:0] tag;
    logic [DW-1:0]   data;
  } entry_t;

  // Sample address of the following byte, wrapping within the 17-bit space.
  function automatic logic [SA_W-1:0] next_sa(input logic [SA_W-1:0] sa);
    return sa + SA_W'(1);
  endfunction

endpackage

// File: rtl/k007232_rom_entry.sv
// One cache line: registered {valid, tag, data} with a fill port and a tag compare.
module k007232_rom_entry
  import k007232_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fill,
  input  logic [SA_W-1:0] fill_tag,
  input  logic [DW-1:0]   fill_data,
  input  logic [SA_W-1:0] cmp_tag,
  output logic [DW-1:0]   value,
  output logic            hit_c
);

  entry_t line;

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (fill) begin
      line <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
    end
  end

  assign value = line.data;
  assign hit_c = line.valid && (line.tag == cmp_tag);

endmodule

// File: rtl/k007232_rom_server.sv
// Sample-ROM responder for one K007232: per-channel cache, round-robin fetch FSM.
// Define K007232_ROM_PREFETCH_EN to add a second line per channel filled with tag + 1.
module k007232_rom_server
  import k007232_pkg::*;
#(
  parameter int unsigned AW   = 22,
  parameter int unsigned BASE = 0
) (
  input  logic            i_EMUCLK,
  input  logic            i_RST,
  input  logic [SA_W-1:0] i_SA,
  input  logic            i_CH,
  output logic [DW-1:0]   o_RAM,
  output logic            o_MEM_RD,
  output logic [AW-1:0]   o_MEM_ADDR,
  input  logic            i_MEM_ACK,
  input  logic [DW-1:0]   i_MEM_DATA,
  output logic            o_LATE
);

  state_t          state;
  logic            fetch_ch;
  logic            last_served;
  logic            prev_ch;
  logic [SA_W-1:0] fetch_tag;
  logic [SA_W-1:0] last_sa [2];
  logic [1:0]      seen;

  logic [1:0]      need_c;
  logic [1:0]      prim_hit_c;
  logic [1:0]      fill_c;
  logic [1:0]      promote_c;
  logic            pick_c;
  logic            ack_fill_c;
  logic            late_c;
  logic [SA_W-1:0] fill_tag_c  [2];
  logic [DW-1:0]   fill_data_c [2];
  logic [DW-1:0]   prim_data   [2];

  function automatic logic [AW-1:0] mem_addr(input logic [SA_W-1:0] sa);
    return AW'(BASE) + AW'(sa);
  endfunction

  // A channel never presented since reset has no address to fetch.
  assign need_c     = seen & ~prim_hit_c;
  assign pick_c     = (need_c == 2'b11) ? ~last_served : need_c[1];
  assign ack_fill_c = (state == FETCH) && i_MEM_ACK;
  assign late_c     = (i_CH != prev_ch) && need_c[prev_ch] && !fill_c[prev_ch];
  assign o_RAM      = prim_data[i_CH];

`ifdef K007232_ROM_PREFETCH_EN
  logic [1:0]      sec_hit_c;
  logic [1:0]      sec_fill_c;
  logic [SA_W-1:0] sec_cmp_c [2];
  logic [DW-1:0]   sec_data  [2];
  logic            pf_held_c;

  // In PREFETCH the second line is checked against the prefetch tag, otherwise against the channel address.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sec_cmp_c[c]  = (state == PREFETCH) ? fetch_tag : last_sa[c];
      sec_fill_c[c] = (state == PREFETCH) && o_MEM_RD && i_MEM_ACK && (fetch_ch == 1'(c));
      promote_c[c]  = (state == IDLE) && need_c[c] && (pick_c == 1'(c)) && sec_hit_c[c];
    end
  end

  assign pf_held_c = sec_hit_c[fetch_ch];

  for (genvar g = 0; g < 2; g++) begin : g_sec
    k007232_rom_entry u_sec (
      .clk       (i_EMUCLK),
      .rst       (i_RST),
      .fill      (sec_fill_c[g]),
      .fill_tag  (fetch_tag),
      .fill_data (i_MEM_DATA),
      .cmp_tag   (sec_cmp_c[g]),
      .value     (sec_data[g]),
      .hit_c     (sec_hit_c[g])
    );
  end
`else
  assign promote_c = '0;
`endif

  // Primary line write source: memory fill, or promotion of the second line.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      fill_c[c]      = (ack_fill_c && (fetch_ch == 1'(c))) || promote_c[c];
      fill_tag_c[c]  = fetch_tag;
      fill_data_c[c] = i_MEM_DATA;
`ifdef K007232_ROM_PREFETCH_EN
      if (promote_c[c]) begin
        fill_tag_c[c]  = last_sa[c];
        fill_data_c[c] = sec_data[c];
      end
`endif
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_prim
    k007232_rom_entry u_prim (
      .clk       (i_EMUCLK),
      .rst       (i_RST),
      .fill      (fill_c[g]),
      .fill_tag  (fill_tag_c[g]),
      .fill_data (fill_data_c[g]),
      .cmp_tag   (last_sa[g]),
      .value     (prim_data[g]),
      .hit_c     (prim_hit_c[g])
    );
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state       <= IDLE;
      o_MEM_RD    <= 1'b0;
      o_MEM_ADDR  <= '0;
      o_LATE      <= 1'b0;
      fetch_ch    <= 1'b0;
      fetch_tag   <= '0;
      last_served <= 1'b1;
      prev_ch     <= 1'b0;
      seen        <= '0;
      last_sa[0]  <= '0;
      last_sa[1]  <= '0;
    end else begin
      o_LATE           <= late_c;
      prev_ch          <= i_CH;
      seen[i_CH]       <= 1'b1;
      last_sa[i_CH]    <= i_SA;
      case (state)
        IDLE: begin
          if (|need_c) begin
            fetch_ch    <= pick_c;
            last_served <= pick_c;
`ifdef K007232_ROM_PREFETCH_EN
            if (|promote_c) begin
              state     <= PREFETCH;
              fetch_tag <= next_sa(last_sa[pick_c]);
            end else
`endif
            begin
              state      <= FETCH;
              o_MEM_RD   <= 1'b1;
              fetch_tag  <= last_sa[pick_c];
              o_MEM_ADDR <= mem_addr(last_sa[pick_c]);
            end
          end
        end
        FETCH: begin
          if (i_MEM_ACK) begin
            o_MEM_RD  <= 1'b0;
`ifdef K007232_ROM_PREFETCH_EN
            state     <= PREFETCH;
            fetch_tag <= next_sa(fetch_tag);
`else
            state     <= IDLE;
`endif
          end
        end
`ifdef K007232_ROM_PREFETCH_EN
        // Pending misses win over a prefetch that has not yet been requested.
        PREFETCH: begin
          if (!o_MEM_RD) begin
            if ((|need_c) || pf_held_c) begin
              state <= IDLE;
            end else begin
              o_MEM_RD   <= 1'b1;
              o_MEM_ADDR <= mem_addr(fetch_tag);
            end
          end else if (i_MEM_ACK) begin
            o_MEM_RD <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k007232_rom_server.sv
// Directed bench for k007232_rom_server; table vectors plus hand-written multi-cycle sequences.
module tb_k007232_rom_server;

  localparam int unsigned AW   = 22;
  localparam int unsigned BASE = 32'h003F_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          ch;
  logic [16:0]   sa;
  logic [7:0]    ram;
  logic          rd;
  logic [AW-1:0] addr;
  logic          ack;
  logic [7:0]    mdata;
  logic          late;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  k007232_rom_server #(.AW(AW), .BASE(BASE)) dut (
    .i_EMUCLK   (clk),
    .i_RST      (rst),
    .i_SA       (sa),
    .i_CH       (ch),
    .o_RAM      (ram),
    .o_MEM_RD   (rd),
    .o_MEM_ADDR (addr),
    .i_MEM_ACK  (ack),
    .i_MEM_DATA (mdata),
    .o_LATE     (late)
  );

  typedef struct {
    logic        ch;
    logic [16:0] sa;
    logic        ack;
    logic [7:0]  data;
    logic [7:0]  ram;
    logic        rd;
    logic [21:0] addr;
    logic        late;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic c, input logic [16:0] a, input logic k, input logic [7:0] d,
                              input logic [7:0] r, input logic q, input logic [21:0] ad, input logic l);
    vec_t v;
    v.ch = c; v.sa = a; v.ack = k; v.data = d; v.ram = r; v.rd = q; v.addr = ad; v.late = l;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic c, input logic [16:0] a);
    rst = 1'b1; ch = c; sa = a; ack = 1'b0; mdata = 8'h00;
    repeat (2) cyc();
    #2;
    chk("reset ram", 32'(ram), 32'h00);
    chk("reset rd", 32'(rd), 32'h0);
    chk("reset late", 32'(late), 32'h0);
    cyc();
    rst = 1'b0;
  endtask

  // Called at a sample point; waits (bounded) for a request, checks it, acks after dly cycles.
  task automatic serve(input logic [21:0] ea, input logic [7:0] d, input int dly, input string nm);
    int n = 0;
    while (!rd && n < 40) begin
      cyc(); #2;
      n++;
    end
    chk({nm, " rd"}, 32'(rd), 32'h1);
    chk({nm, " addr"}, 32'(addr), 32'(ea));
    repeat (dly) begin
      cyc(); #2;
    end
    cyc(); ack = 1'b1; mdata = d; #2;
    cyc(); ack = 1'b0; mdata = 8'h00; #2;
  endtask

  initial begin
`ifndef K007232_ROM_PREFETCH_EN
    // First fill, then a long-latency fill with channel toggling.
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h00, 0, 22'h0,      0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h00, 0, 22'h0,      0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h00, 1, 22'h3F0100, 0));
    vt.push_back(mk(0, 17'h100, 1, 8'h5A, 8'h00, 1, 22'h3F0100, 0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 0, 22'h0,      0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 0, 22'h0,      0));
    vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'h00, 0, 22'h0,      0));
    vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'h00, 0, 22'h0,      0));
    vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'h00, 1, 22'h3F0300, 0));
    vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'h00, 1, 22'h3F0300, 0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 1, 22'h3F0300, 0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 1, 22'h3F0300, 1));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 1, 22'h3F0300, 0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 1, 22'h3F0300, 0));
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'h00, 1, 22'h3F0300, 0));
    vt.push_back(mk(0, 17'h100, 1, 8'hC3, 8'h5A, 1, 22'h3F0300, 0));
    vt.push_back(mk(0, 17'h100, 0, 8'h00, 8'h5A, 0, 22'h0,      0));
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(1, 17'h300, 0, 8'h00, 8'hC3, 0, 22'h0,      0));

    do_reset(1'b0, 17'h100);
    for (int i = 0; i < vt.size(); i++) begin
      if (i > 0) cyc();
      ch = vt[i].ch; sa = vt[i].sa; ack = vt[i].ack; mdata = vt[i].data;
      #2;
      chk($sformatf("vec%0d ram", i), 32'(ram), 32'(vt[i].ram));
      chk($sformatf("vec%0d rd", i), 32'(rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d late", i), 32'(late), 32'(vt[i].late));
      if (vt[i].rd) chk($sformatf("vec%0d addr", i), 32'(addr), 32'(vt[i].addr));
    end

    // Round-robin: A first after reset, then a tie with A served last goes to B.
    do_reset(1'b0, 17'h10);
    cyc(); ch = 1'b1; sa = 17'h20;
    cyc(); ch = 1'b0; sa = 17'h30; #2;
    chk("rr first rd", 32'(rd), 32'h1);
    serve(22'h3F0010, 8'h11, 1, "rr_a");
    chk("rr old tag ram", 32'(ram), 32'h11);
    chk("rr idle rd", 32'(rd), 32'h0);
    serve(22'h3F0020, 8'h22, 0, "rr_b");
    serve(22'h3F0030, 8'h33, 0, "rr_a2");
    chk("rr a2 ram", 32'(ram), 32'h33);
    cyc(); ch = 1'b1; sa = 17'h20; #2;
    chk("hit b ram", 32'(ram), 32'h22);
    for (int k = 0; k < 4; k++) begin
      cyc(); #2;
      chk($sformatf("hit quiet rd%0d", k), 32'(rd), 32'h0);
    end

    // Address wrap into AW, then reset while a request is outstanding.
    do_reset(1'b0, 17'h1FFFF);
    cyc(); #2;
    cyc(); #2;
    chk("wrap rd", 32'(rd), 32'h1);
    chk("wrap addr", 32'(addr), 32'h00FFFF);
    cyc(); rst = 1'b1; #2;
    cyc(); rst = 1'b0; ack = 1'b1; mdata = 8'hEE; #2;
    chk("rst ack rd", 32'(rd), 32'h0);
    chk("rst ack addr", 32'(addr), 32'h0);
    chk("rst ack late", 32'(late), 32'h0);
    chk("rst ack ram", 32'(ram), 32'h00);
    cyc(); ack = 1'b0; mdata = 8'h00; #2;
    chk("rst ignored ram", 32'(ram), 32'h00);
    serve(22'h00FFFF, 8'h77, 0, "post_rst");
    chk("post_rst ram", 32'(ram), 32'h77);
`else
    // Prefetch of 0x1FFFF + 1 wraps to 0x00000, which is then promoted without a fetch.
    do_reset(1'b0, 17'h1FFFF);
    serve(22'h00FFFF, 8'hAB, 0, "pf_fill");
    serve(22'h3F0000, 8'hCD, 0, "pf_next");
    chk("pf ram", 32'(ram), 32'hAB);
    cyc(); sa = 17'h00000; #2;
    chk("pf miss ram", 32'(ram), 32'hAB);
    chk("pf miss rd", 32'(rd), 32'h0);
    cyc(); #2;
    chk("pf promote rd", 32'(rd), 32'h0);
    cyc(); #2;
    chk("pf promoted ram", 32'(ram), 32'hCD);
    chk("pf promoted rd", 32'(rd), 32'h0);
    serve(22'h3F0001, 8'hEF, 0, "pf_chain");
    chk("pf chain ram", 32'(ram), 32'hCD);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
